svt_input_channel: RTL and testbench

- Per-channel SVT cable receiver that sits directly upstream of the GigaFitter core's event assembly; four instances, one per SVT input (W0..W3).
- Captures the 23-bit polarity-corrected word on each data-strobe rising edge, buffers it in a FIFO, and throttles the sender through hold.
- Counts complete events so the core starts a fit only when every channel holds one.
- Checks end-event tag continuity and flags lost sync.

---
 rtl/gf_svt_pkg.sv | 17 +
 rtl/svt_fifo_ram.sv | 37 +++
 rtl/svt_input_channel.sv | 154 +++++++++++++++
 tb/tb_svt_input_channel.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_svt_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// gf_svt_pkg: SVT word layout and FIFO sizing shared by the input channels
// and the four-channel event gate in the GigaFitter core.
package gf_svt_pkg;

   localparam int SVT_W   = 23;
   localparam int EE_BIT  = 22;
   localparam int TAG_LSB = 0;

   localparam int DEF_DEPTH_LOG2  = 9;
   localparam int DEF_HOLD_MARGIN = 32;

   typedef logic [SVT_W-1:0] svt_word_t;

endpackage
`default_nettype wire

// File: rtl/svt_fifo_ram.sv
`timescale 1ns/1ps
`default_nettype none
// svt_fifo_ram: simple dual-port storage for one SVT channel, synchronous
// write and registered read so it maps onto a single block RAM.
module svt_fifo_ram
   import gf_svt_pkg::*;
#(
   parameter int ADDR_W = DEF_DEPTH_LOG2
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [SVT_W-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [SVT_W-1:0]  rdata_o
);

   localparam int DEPTH = 1 << ADDR_W;

   svt_word_t mem_q [DEPTH];
   svt_word_t rdata_q;

   // No reset on the array or read register: block RAM cannot be cleared.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/svt_input_channel.sv
`timescale 1ns/1ps
`default_nettype none
// svt_input_channel: one SVT cable receiver - strobe capture, word FIFO with
// hold back-pressure, complete-event counting and end-event tag checking.
module svt_input_channel
   import gf_svt_pkg::*;
#(
   parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
   parameter int HOLD_MARGIN = DEF_HOLD_MARGIN,
   parameter int TAG_W       = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [SVT_W-1:0]      data_in,
   input  logic                  ds,
   output logic                  hold,
   input  logic                  rd_en,
   output logic [SVT_W-1:0]      dout,
   output logic                  dout_valid,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   fill,
   output logic                  ev_avail,
   output logic [7:0]            ev_count,
   input  logic                  err_clear,
   output logic                  lost_sync_err,
   output logic                  overflow_err
);

   localparam int                DEPTH    = 1 << DEPTH_LOG2;
   localparam int                FILL_W   = DEPTH_LOG2 + 1;
   localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);
   localparam logic [FILL_W-1:0] HOLD_LVL = FILL_W'(DEPTH - HOLD_MARGIN);

   svt_word_t             s1_data_q;
   logic                  s1_ds_q, s2_ds_q;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [FILL_W-1:0]     fill_q, fill_d;
   logic                  hold_q;
   logic                  dout_valid_q, rd_seen_q;
   logic [7:0]            ev_q, ev_d;
   logic [TAG_W-1:0]      exp_tag_q, exp_tag_d;
   logic                  lost_q, ovf_q;
   logic                  ee_mem_q [DEPTH];

   logic                  strobe, is_full, is_empty, rd_ok, wr_ok;
   logic                  ee_wr, ee_rd, ee_seen, tag_ok;
   logic [TAG_W-1:0]      rx_tag;
   svt_word_t             ram_rdata;

   assign strobe   = s1_ds_q & ~s2_ds_q;
   assign is_full  = (fill_q == FULL_LVL);
   assign is_empty = (fill_q == '0);
   assign rd_ok    = rd_en & ~is_empty;
   // A pop in the same cycle frees the slot the write needs.
   assign wr_ok    = strobe & (~is_full | rd_ok);

   assign ee_wr    = wr_ok & s1_data_q[EE_BIT];
   assign ee_rd    = rd_ok & ee_mem_q[rd_ptr_q];
   assign ee_seen  = strobe & s1_data_q[EE_BIT];
   assign rx_tag   = s1_data_q[TAG_LSB +: TAG_W];
   assign tag_ok   = (rx_tag == exp_tag_q);

   always_comb begin
      fill_d = fill_q;
      if (wr_ok && !rd_ok) begin
         fill_d = fill_q + FILL_W'(1);
      end else if (rd_ok && !wr_ok) begin
         fill_d = fill_q - FILL_W'(1);
      end
   end

   always_comb begin
      ev_d = ev_q;
      if (ee_wr && !ee_rd && ev_q != 8'hFF) begin
         ev_d = ev_q + 8'd1;
      end else if (ee_rd && !ee_wr && ev_q != 8'h00) begin
         ev_d = ev_q - 8'd1;
      end
   end

   always_comb begin
      exp_tag_d = exp_tag_q;
      if (ee_seen) begin
         exp_tag_d = tag_ok ? exp_tag_q + TAG_W'(1) : rx_tag + TAG_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_data_q    <= '0;
         s1_ds_q      <= 1'b0;
         s2_ds_q      <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fill_q       <= '0;
         hold_q       <= 1'b1;
         dout_valid_q <= 1'b0;
         rd_seen_q    <= 1'b0;
         ev_q         <= '0;
         exp_tag_q    <= '0;
         lost_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         s1_data_q    <= data_in;
         s1_ds_q      <= ds;
         s2_ds_q      <= s1_ds_q;
         if (wr_ok) begin
            wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
         end
         if (rd_ok) begin
            rd_ptr_q  <= rd_ptr_q + DEPTH_LOG2'(1);
            rd_seen_q <= 1'b1;
         end
         fill_q       <= fill_d;
         hold_q       <= (fill_d >= HOLD_LVL);
         dout_valid_q <= rd_ok;
         ev_q         <= ev_d;
         exp_tag_q    <= exp_tag_d;
         lost_q       <= (lost_q & ~err_clear) | (ee_seen & ~tag_ok);
         ovf_q        <= (ovf_q & ~err_clear) | (strobe & ~wr_ok);
      end
   end

   // Per-slot EE shadow lets ev_count drop on the pop edge itself.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         ee_mem_q[wr_ptr_q] <= s1_data_q[EE_BIT];
      end
   end

   svt_fifo_ram #(
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_ok),
      .waddr_i (wr_ptr_q),
      .wdata_i (s1_data_q),
      .re_i    (rd_ok),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   assign dout          = rd_seen_q ? ram_rdata : '0;
   assign dout_valid    = dout_valid_q;
   assign empty         = is_empty;
   assign fill          = fill_q;
   assign hold          = hold_q;
   assign ev_count      = ev_q;
   assign ev_avail      = (ev_q != 8'h00);
   assign lost_sync_err = lost_q;
   assign overflow_err  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_svt_input_channel.sv
`timescale 1ns/1ps
`default_nettype none
// tb_svt_input_channel: directed vectors with hand-computed expectations.
module tb_svt_input_channel;
   import gf_svt_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n, ds, rd_en, err_clear;
   logic [22:0] data_in, dout;
   logic        hold, dout_valid, empty, ev_avail, lost_sync_err, overflow_err;
   logic [9:0]  fill;
   logic [7:0]  ev_count;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [22:0] EE = 23'h400000;

   svt_input_channel #(
      .DEPTH_LOG2  (9),
      .HOLD_MARGIN (32),
      .TAG_W       (8)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .data_in       (data_in),
      .ds            (ds),
      .hold          (hold),
      .rd_en         (rd_en),
      .dout          (dout),
      .dout_valid    (dout_valid),
      .empty         (empty),
      .fill          (fill),
      .ev_avail      (ev_avail),
      .ev_count      (ev_count),
      .err_clear     (err_clear),
      .lost_sync_err (lost_sync_err),
      .overflow_err  (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ds high for one sampled edge; the write lands on the following edge.
   task automatic pulse(input logic [22:0] w);
      data_in = w;
      ds      = 1'b1;
      tick();
      ds      = 1'b0;
      tick();
   endtask

   task automatic rd_check(input string tag, input logic [22:0] exp);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk({tag, "_valid"}, 32'(dout_valid), 32'd1);
      chk({tag, "_data"}, 32'(dout), 32'(exp));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      int bad;
      reset_n   = 1'b0;
      ds        = 1'b0;
      rd_en     = 1'b0;
      err_clear = 1'b0;
      data_in   = '0;
      tick();
      tick();
      chk("rst_fill", 32'(fill), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_hold", 32'(hold), 32'd1);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_dvalid", 32'(dout_valid), 32'd0);
      chk("rst_ev", 32'(ev_count), 32'd0);
      chk("rst_errs", 32'({lost_sync_err, overflow_err}), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("rel_hold", 32'(hold), 32'd0);

      // Basic event of three words.
      pulse(23'h000001);
      chk("lat_empty", 32'(empty), 32'd0);
      pulse(23'h000002);
      pulse(EE | 23'h000000);
      chk("ev3_fill", 32'(fill), 32'd3);
      chk("ev3_count", 32'(ev_count), 32'd1);
      chk("ev3_avail", 32'(ev_avail), 32'd1);
      chk("ev3_hold", 32'(hold), 32'd0);
      chk("ev3_lost", 32'(lost_sync_err), 32'd0);
      rd_check("rd0", 23'h000001);
      rd_check("rd1", 23'h000002);
      chk("ev_before_ee_pop", 32'(ev_count), 32'd1);
      rd_check("rd2", EE);
      chk("ev_after_pop", 32'(ev_count), 32'd0);
      chk("avail_after_pop", 32'(ev_avail), 32'd0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("rd_empty_valid", 32'(dout_valid), 32'd0);
      chk("rd_empty_hold_dout", 32'(dout), 32'(EE));

      // Level-held strobe gives a single write.
      data_in = 23'h0000AA;
      ds      = 1'b1;
      repeat (10) tick();
      ds = 1'b0;
      tick();
      chk("held_ds_fill", 32'(fill), 32'd1);
      rd_check("held_ds_rd", 23'h0000AA);

      // Fill to the hold threshold, then to full, then overflow.
      for (int i = 0; i < 480; i++) begin
         pulse(23'(i));
         if (i == 478) chk("hold_at_479", 32'(hold), 32'd0);
      end
      chk("fill_480", 32'(fill), 32'd480);
      chk("hold_at_480", 32'(hold), 32'd1);
      for (int i = 480; i < 512; i++) pulse(23'(i));
      chk("fill_512", 32'(fill), 32'd512);
      chk("no_ovf_yet", 32'(overflow_err), 32'd0);
      pulse(23'h007777);
      chk("ovf_fill", 32'(fill), 32'd512);
      chk("ovf_set", 32'(overflow_err), 32'd1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("ovf_clear", 32'(overflow_err), 32'd0);

      // Full: read and write in the same cycle.
      data_in = 23'h001234;
      ds      = 1'b1;
      tick();
      ds    = 1'b0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("full_rw_fill", 32'(fill), 32'd512);
      chk("full_rw_ovf", 32'(overflow_err), 32'd0);
      chk("full_rw_dout", 32'(dout), 32'd0);
      bad = 0;
      for (int i = 1; i < 513; i++) begin
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
         if (dout_valid !== 1'b1 || dout !== ((i == 512) ? 23'h001234 : 23'(i))) begin
            bad++;
            if (bad < 4) $display("readback word %0d: got 0x%0h", i, dout);
         end
      end
      chk("readback_bad_words", 32'(bad), 32'd0);
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_hold", 32'(hold), 32'd0);

      // Empty: read and write in the same cycle.
      data_in = 23'h000055;
      ds      = 1'b1;
      tick();
      ds    = 1'b0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("empty_rw_fill", 32'(fill), 32'd1);
      chk("empty_rw_valid", 32'(dout_valid), 32'd0);
      rd_check("empty_rw_rd", 23'h000055);

      // Tag continuity.
      do_reset();
      pulse(EE | 23'd0);
      pulse(EE | 23'd1);
      chk("tag01_lost", 32'(lost_sync_err), 32'd0);
      pulse(EE | 23'd3);
      chk("tag3_lost", 32'(lost_sync_err), 32'd1);
      pulse(EE | 23'd4);
      chk("tag4_sticky", 32'(lost_sync_err), 32'd1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("tag_clear", 32'(lost_sync_err), 32'd0);
      pulse(EE | 23'd5);
      chk("tag5_lost", 32'(lost_sync_err), 32'd0);
      pulse(EE | 23'd254);
      chk("tag254_lost", 32'(lost_sync_err), 32'd1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      pulse(EE | 23'd255);
      pulse(EE | 23'd0);
      chk("tag_wrap_lost", 32'(lost_sync_err), 32'd0);
      chk("tag_ev_count", 32'(ev_count), 32'd8);
      // Mismatch coinciding with err_clear: the error stays.
      data_in   = EE | 23'd9;
      ds        = 1'b1;
      tick();
      ds        = 1'b0;
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("err_wins", 32'(lost_sync_err), 32'd1);
      chk("tag_ev_count9", 32'(ev_count), 32'd9);

      // Reset in the middle of buffered data.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         pulse((i % 50 == 49) ? (EE | 23'(i / 50)) : 23'(i));
      end
      chk("pre_rst_fill", 32'(fill), 32'd100);
      chk("pre_rst_ev", 32'(ev_count), 32'd2);
      reset_n = 1'b0;
      #1;
      chk("async_rst_fill", 32'(fill), 32'd0);
      chk("async_rst_ev", 32'(ev_count), 32'd0);
      chk("async_rst_avail", 32'(ev_avail), 32'd0);
      chk("async_rst_empty", 32'(empty), 32'd1);
      chk("async_rst_hold", 32'(hold), 32'd1);
      chk("async_rst_errs", 32'({lost_sync_err, overflow_err}), 32'd0);
      tick();
      chk("in_rst_hold", 32'(hold), 32'd1);
      reset_n = 1'b1;
      tick();
      chk("post_rst_hold", 32'(hold), 32'd0);
      chk("post_rst_fill", 32'(fill), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
